vc_dest_arbiter: RTL and testbench

Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmission-layer datapath. Each cycle it selects at most one VC head word, pops it, and pushes it one cycle later into the destination FIFO named by the word's destination bit. It honours destination almost-full back-pressure and reports its own idle/active/blocked status and per-destination word counts to the main control logic.

---
 rtl/vc_dest_arbiter_pkg.sv | 20 ++
 rtl/vc_dest_arbiter_if.sv | 38 +++
 rtl/vc_dest_arbiter_sat_counter.sv | 24 ++
 rtl/vc_dest_arbiter.sv | 105 ++++++++++
 tb/tb_vc_dest_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/vc_dest_arbiter_pkg.sv
// Shared constants and state encoding for the VC-to-destination arbiter.
// The optional feature macro is VC_ROUND_ROBIN_EN (see vc_dest_arbiter.sv).
package vc_dest_arbiter_pkg;

  localparam int DATA_WIDTH_DEF  = 6;
  localparam int COUNT_WIDTH_DEF = 8;
  localparam int DEST_BIT        = DATA_WIDTH_DEF - 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_BLOCKED = 2'd2
  } arb_state_e;

  // Position of the destination-select bit for any word width.
  function automatic int dest_bit_of(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Bundle of VC-side, destination-side and status signals of the arbiter.
// Handshake: a VC head is consumed in the cycle its pop is high (show-ahead, valid while empty is low); a push marks data_out valid for one cycle.
interface vc_dest_arbiter_if #(
  parameter int data_width  = 6,
  parameter int count_width = 8
);
  logic                   active_in;
  logic [data_width-1:0]  vc0_data;
  logic [data_width-1:0]  vc1_data;
  logic                   vc0_empty;
  logic                   vc1_empty;
  logic                   d0_almost_full;
  logic                   d1_almost_full;
  logic                   vc0_pop;
  logic                   vc1_pop;
  logic                   d0_push;
  logic                   d1_push;
  logic [data_width-1:0]  data_out;
  logic                   arb_idle;
  logic                   arb_active;
  logic                   arb_blocked;
  logic [count_width-1:0] count_d0;
  logic [count_width-1:0] count_d1;

  modport master (
    output active_in, vc0_data, vc1_data, vc0_empty, vc1_empty,
           d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out,
           arb_idle, arb_active, arb_blocked, count_d0, count_d1
  );

  modport slave (
    input  active_in, vc0_data, vc1_data, vc0_empty, vc1_empty,
           d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out,
           arb_idle, arb_active, arb_blocked, count_d0, count_d1
  );
endinterface

// File: rtl/vc_dest_arbiter_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/vc_dest_arbiter.sv
// Picks at most one VC head per cycle, pops it, and pushes it next cycle to D0/D1.
// Define VC_ROUND_ROBIN_EN to alternate between VCs when both are eligible.
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH_DEF,
  parameter int count_width = COUNT_WIDTH_DEF
) (
  input logic            clk,
  input logic            reset,
  vc_dest_arbiter_if.slave bus
);
  localparam int DBIT = dest_bit_of(data_width);

  arb_state_e            state_q, state_d;
  logic                  push0_q, push0_d;
  logic                  push1_q, push1_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  elig0, elig1, grant0, grant1;
  logic                  af0, af1;
  logic [data_width-1:0] grant_word;

  // Almost-full of the destination each head is aimed at.
  assign af0   = bus.vc0_data[DBIT] ? bus.d1_almost_full : bus.d0_almost_full;
  assign af1   = bus.vc1_data[DBIT] ? bus.d1_almost_full : bus.d0_almost_full;
  assign elig0 = !bus.vc0_empty && bus.active_in && !af0;
  assign elig1 = !bus.vc1_empty && bus.active_in && !af1;

`ifdef VC_ROUND_ROBIN_EN
  logic last_q;  // 1 = VC1 granted last

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              last_q <= 1'b1;
    else if (grant0 | grant1) last_q <= grant1;
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef VC_ROUND_ROBIN_EN
    if (elig0 && elig1) begin
      grant0 = last_q;
      grant1 = !last_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
`else
    grant0 = elig0;
    grant1 = elig1 && !elig0;
`endif
  end

  assign grant_word = grant1 ? bus.vc1_data : bus.vc0_data;

  always_comb begin
    state_d = ST_IDLE;
    push0_d = 1'b0;
    push1_d = 1'b0;
    data_d  = data_q;
    if (grant0 || grant1) begin
      state_d = ST_ACTIVE;
      data_d  = grant_word;
      push0_d = !grant_word[DBIT];
      push1_d = grant_word[DBIT];
    end else if (!bus.active_in || (bus.vc0_empty && bus.vc1_empty)) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_BLOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      push0_q <= push0_d;
      push1_q <= push1_d;
      data_q  <= data_d;
    end
  end

  // Pops are combinational, so gate them with reset explicitly.
  assign bus.vc0_pop     = grant0 && reset;
  assign bus.vc1_pop     = grant1 && reset;
  assign bus.d0_push     = push0_q;
  assign bus.d1_push     = push1_q;
  assign bus.data_out    = data_q;
  assign bus.arb_idle    = (state_q == ST_IDLE);
  assign bus.arb_active  = (state_q == ST_ACTIVE);
  assign bus.arb_blocked = (state_q == ST_BLOCKED);

  sat_counter #(.W(count_width)) u_cnt_d0 (
    .clk(clk), .rst_n(reset), .inc_i(push0_q), .count_o(bus.count_d0)
  );

  sat_counter #(.W(count_width)) u_cnt_d1 (
    .clk(clk), .rst_n(reset), .inc_i(push1_q), .count_o(bus.count_d1)
  );
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter; expected values are hand-computed.
module tb_vc_dest_arbiter;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  vc_dest_arbiter_if #(.data_width(6), .count_width(8)) bus ();

  vc_dest_arbiter #(.data_width(6), .count_width(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.active_in      = 1'b1;
    bus.vc0_data       = '0;
    bus.vc1_data       = '0;
    bus.vc0_empty      = 1'b1;
    bus.vc1_empty      = 1'b1;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;

    // Reset values
    #12;
    chk("rst_pop0", bus.vc0_pop, 0);
    chk("rst_pop1", bus.vc1_pop, 0);
    chk("rst_push", {bus.d0_push, bus.d1_push}, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_cnt", {bus.count_d0, bus.count_d1}, 0);
    chk("rst_flags", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b100);
    reset = 1'b1;
    step();
    chk("idle_after_rst", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b100);

    // Single word from VC0 to D0
    bus.vc0_data = 6'b000101; bus.vc0_empty = 1'b0;
    #1;
    chk("t2_pop", {bus.vc0_pop, bus.vc1_pop}, 2'b10);
    step();
    bus.vc0_empty = 1'b1;
    chk("t2_push", {bus.d0_push, bus.d1_push}, 2'b10);
    chk("t2_data", bus.data_out, 6'b000101);
    chk("t2_active", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b010);
    step();
    chk("t2_push_off", {bus.d0_push, bus.d1_push}, 2'b00);
    chk("t2_cnt0", bus.count_d0, 1);
    chk("t2_idle", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b100);

    // VC0 head blocked by D1 almost-full, VC1 still granted
    bus.vc0_data = 6'b010110; bus.vc0_empty = 1'b0;
    bus.vc1_data = 6'b000100; bus.vc1_empty = 1'b0;
    bus.d1_almost_full = 1'b1;
    #1;
    chk("t3_pop", {bus.vc0_pop, bus.vc1_pop}, 2'b01);
    step();
    bus.vc1_empty = 1'b1;
    #1;
    chk("t3_push", {bus.d0_push, bus.d1_push}, 2'b10);
    chk("t3_data", bus.data_out, 6'b000100);
    chk("t3_nopop", {bus.vc0_pop, bus.vc1_pop}, 2'b00);
    step();
    chk("t3_blocked", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b001);
    chk("t3_cnt0", bus.count_d0, 2);
    chk("t3_cnt1", bus.count_d1, 0);
    bus.vc0_empty = 1'b1;
    bus.d1_almost_full = 1'b0;

    // Both VCs hold D0 words for four cycles (last grant was VC1)
    bus.vc0_data = 6'b000001; bus.vc0_empty = 1'b0;
    bus.vc1_data = 6'b000010; bus.vc1_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_pop;
      logic [5:0] exp_word;
`ifdef VC_ROUND_ROBIN_EN
      exp_pop  = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_pop  = 2'b10;
`endif
      exp_word = exp_pop[1] ? 6'b000001 : 6'b000010;
      #1;
      chk($sformatf("t4_pop%0d", i), {bus.vc0_pop, bus.vc1_pop}, exp_pop);
      step();
      chk($sformatf("t4_data%0d", i), bus.data_out, exp_word);
    end
    bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b1;
    step();
    chk("t4_cnt0", bus.count_d0, 6);

    // One word to D1 (VC0 was not the last grant in round-robin; uncontested anyway)
    bus.vc0_data = 6'b010110; bus.vc0_empty = 1'b0;
    #1;
    chk("t5_pop", {bus.vc0_pop, bus.vc1_pop}, 2'b10);
    step();
    bus.vc0_empty = 1'b1;
    chk("t5_push", {bus.d0_push, bus.d1_push}, 2'b01);
    chk("t5_data", bus.data_out, 6'b010110);
    step();
    chk("t5_cnt1", bus.count_d1, 1);

    // 300 consecutive D0 pushes saturate count_d0
    bus.vc0_data = 6'b000011; bus.vc0_empty = 1'b0;
    repeat (300) step();
    bus.vc0_empty = 1'b1;
    step();
    step();
    chk("t6_sat", bus.count_d0, 255);
    step();
    chk("t6_sat_hold", bus.count_d0, 255);
    chk("t6_cnt1", bus.count_d1, 1);

    // active_in drops the cycle after a pop
    bus.vc0_data = 6'b000101; bus.vc0_empty = 1'b0;
    #1;
    chk("t7_pop", bus.vc0_pop, 1);
    step();
    bus.active_in = 1'b0;
    #1;
    chk("t7_nopop", {bus.vc0_pop, bus.vc1_pop}, 2'b00);
    chk("t7_push", bus.d0_push, 1);
    step();
    chk("t7_push_off", {bus.d0_push, bus.d1_push}, 2'b00);
    chk("t7_idle", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b100);
    chk("t7_nopop2", {bus.vc0_pop, bus.vc1_pop}, 2'b00);

    // Reset pulsed during a pop cycle
    bus.active_in = 1'b1;
    #1;
    chk("t8_pop", bus.vc0_pop, 1);
    reset = 1'b0;
    #1;
    chk("t8_pop_forced", {bus.vc0_pop, bus.vc1_pop}, 2'b00);
    step();
    chk("t8_push", {bus.d0_push, bus.d1_push}, 2'b00);
    chk("t8_data", bus.data_out, 0);
    chk("t8_cnt", {bus.count_d0, bus.count_d1}, 0);
    chk("t8_flags", {bus.arb_idle, bus.arb_active, bus.arb_blocked}, 3'b100);
    bus.vc0_empty = 1'b1;
    #2;
    reset = 1'b1;
    step();
    chk("t8_after", {bus.d0_push, bus.d1_push, bus.arb_idle}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
